// File: rtl/tl_tx_cpl_write_handler_pkg.sv
// Shared constants, FSM encoding and length helper for the TX completion writer.
// Length field value 0 stands for the maximum payload of 1024 DW.
package tl_tx_cpl_write_handler_pkg;

    localparam int HDR_WIDTH         = 96;
    localparam int BEAT_WIDTH        = 1024;
    localparam int PAYLOAD_LENGTH    = 10;
    localparam int DATA_CREDIT_WIDTH = 12;
    localparam int HDR_CREDIT_WIDTH  = 8;
    localparam int FREE_ENTRY_WIDTH  = 8;

    localparam int DW_PER_BEAT   = 32;
    localparam int DW_PER_ENTRY  = 8;
    localparam int DW_PER_CREDIT = 4;

    // Counter holding beats-1; 1024 DW / 32 DW per beat needs 5 bits
    localparam int BEAT_CNT_WIDTH = PAYLOAD_LENGTH - 5;

    // Entries written by a full 32 DW beat
    localparam logic [2:0] FULL_BEAT_INC = 3'(DW_PER_BEAT / DW_PER_ENTRY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_XFER  = 2'd2
    } cpl_state_e;

    // Expand the length field into a true DW count (0 -> 1024)
    function automatic logic [PAYLOAD_LENGTH:0] payload_dw(
        input logic [PAYLOAD_LENGTH-1:0] len
    );
        if (len == '0)
            payload_dw = {1'b1, {PAYLOAD_LENGTH{1'b0}}};
        else
            payload_dw = {1'b0, len};
    endfunction

endpackage

// File: rtl/tl_tx_cpl_write_handler_length_decode.sv
// Combinational decode of a completion length into beats, FC credits,
// buffer entries and the entry increment of the final beat.
module tl_tx_cpl_length_decode
    import tl_tx_cpl_write_handler_pkg::*;
(
    input  logic                         fmt_data,
    input  logic [PAYLOAD_LENGTH-1:0]    length,
    output logic [BEAT_CNT_WIDTH-1:0]    beats_m1,
    output logic [DATA_CREDIT_WIDTH-1:0] credits,
    output logic [FREE_ENTRY_WIDTH-1:0]  entries,
    output logic [2:0]                   last_inc
);

    logic [PAYLOAD_LENGTH:0] dw;
    logic [PAYLOAD_LENGTH:0] dw_m1;

    assign dw    = payload_dw(length);
    assign dw_m1 = dw - 1'b1;

    // Ceil divisions expressed as ((n-1) >> k) + 1; a Cpl carries no data
    always_comb begin
        beats_m1 = '0;
        credits  = '0;
        entries  = '0;
        last_inc = '0;
        if (fmt_data) begin
            beats_m1 = BEAT_CNT_WIDTH'(dw_m1 >> 5);
            credits  = DATA_CREDIT_WIDTH'(dw_m1 >> 2) + 1'b1;
            entries  = FREE_ENTRY_WIDTH'(dw_m1 >> 3) + 1'b1;
            // Residue 0 mod 32 gives dw_m1[4:3]=3, i.e. a full beat of 4
            last_inc = {1'b0, dw_m1[4:3]} + 3'd1;
        end
    end

endmodule

// File: rtl/tl_tx_cpl_write_handler.sv
// TX completion writer: gates a completion TLP on FC credits and buffer
// space, then streams header and payload beats into the TX CPL buffers.
// Optional feature macro: TL_TX_CPL_LAST_CHECK_EN (last-marker mismatch error).
module tl_tx_cpl_write_handler
    import tl_tx_cpl_write_handler_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_n_rst,
    input  logic                         i_cpl_valid,
    output logic                         o_cpl_ready,
    input  logic                         i_cpl_fmt_data_bit,
    input  logic [PAYLOAD_LENGTH-1:0]    i_cpl_length,
    input  logic [HDR_WIDTH-1:0]         i_cpl_hdr,
    input  logic [BEAT_WIDTH-1:0]        i_cpl_data,
    input  logic                         i_cpl_last,
    input  logic [HDR_CREDIT_WIDTH-1:0]  i_fc_hdr_credits_avail,
    input  logic [DATA_CREDIT_WIDTH-1:0] i_fc_data_credits_avail,
    output logic                         o_fc_hdr_consume,
    output logic                         o_fc_data_consume,
    output logic [DATA_CREDIT_WIDTH-1:0] o_fc_data_consume_value,
    input  logic                         i_buf_hdr_full,
    input  logic [FREE_ENTRY_WIDTH-1:0]  i_buf_data_free_entries,
    output logic                         o_buf_hdr_wr_en,
    output logic [HDR_WIDTH-1:0]         o_buf_hdr_wr_data,
    output logic                         o_buf_data_wr_en,
    output logic [2:0]                   o_buf_data_wr_inc,
    output logic [BEAT_WIDTH-1:0]        o_buf_data_wr_data,
    output logic                         o_cpl_done,
    output logic                         o_cpl_err
);

    cpl_state_e                   state_q;
    cpl_state_e                   state_d;
    logic [BEAT_CNT_WIDTH-1:0]    beat_cnt_q;
    logic                         fmt_q;
    logic [PAYLOAD_LENGTH-1:0]    len_q;
    logic [HDR_WIDTH-1:0]         hdr_q;

    logic [BEAT_CNT_WIDTH-1:0]    beats_m1;
    logic [DATA_CREDIT_WIDTH-1:0] credits;
    logic [FREE_ENTRY_WIDTH-1:0]  entries;
    logic [2:0]                   last_inc;

    logic in_xfer;
    logic cpl_hs;
    logic first_beat;
    logic last_beat;
    logic space_ok;

    tl_tx_cpl_length_decode u_len_dec (
        .fmt_data (fmt_q),
        .length   (len_q),
        .beats_m1 (beats_m1),
        .credits  (credits),
        .entries  (entries),
        .last_inc (last_inc)
    );

    assign in_xfer    = (state_q == ST_XFER);
    assign cpl_hs     = in_xfer && i_cpl_valid;
    assign first_beat = (beat_cnt_q == beats_m1);
    assign last_beat  = (beat_cnt_q == '0);

    // The whole TLP is reserved up front, so the payload never stalls
    assign space_ok = (i_fc_hdr_credits_avail != '0)
                   && !i_buf_hdr_full
                   && (!fmt_q
                       || ((i_fc_data_credits_avail >= credits)
                           && (i_buf_data_free_entries >= entries)));

    // State register
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: IDLE -> CHECK -> XFER -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_cpl_valid) state_d = ST_CHECK;
            ST_CHECK: if (space_ok)    state_d = ST_XFER;
            ST_XFER:  if (cpl_hs && last_beat) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture the first-beat fields and walk the beat counter down
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            fmt_q      <= 1'b0;
            len_q      <= '0;
            hdr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && i_cpl_valid) begin
                fmt_q <= i_cpl_fmt_data_bit;
                len_q <= i_cpl_length;
                hdr_q <= i_cpl_hdr;
            end
            // Counter loads once the latched length has been decoded
            if (state_q == ST_CHECK && space_ok)
                beat_cnt_q <= beats_m1;
            else if (cpl_hs && !last_beat)
                beat_cnt_q <= beat_cnt_q - 1'b1;
        end
    end

    // Strobes are single-cycle and derived from state plus handshake
    always_comb begin
        o_cpl_ready             = 1'b0;
        o_buf_hdr_wr_en         = 1'b0;
        o_fc_hdr_consume        = 1'b0;
        o_fc_data_consume       = 1'b0;
        o_fc_data_consume_value = '0;
        o_buf_data_wr_en        = 1'b0;
        o_buf_data_wr_inc       = '0;
        o_buf_data_wr_data      = '0;
        o_cpl_done              = 1'b0;
        if (in_xfer) begin
            o_cpl_ready        = 1'b1;
            o_buf_data_wr_data = i_cpl_data;
            if (i_cpl_valid) begin
                o_buf_hdr_wr_en   = first_beat;
                o_fc_hdr_consume  = first_beat;
                o_fc_data_consume = first_beat && fmt_q;
                if (first_beat && fmt_q)
                    o_fc_data_consume_value = credits;
                o_buf_data_wr_en = fmt_q;
                if (fmt_q)
                    o_buf_data_wr_inc = last_beat ? last_inc
                                                  : FULL_BEAT_INC;
                o_cpl_done = last_beat;
            end
        end
    end

    assign o_buf_hdr_wr_data = hdr_q;

`ifdef TL_TX_CPL_LAST_CHECK_EN
    // Slave last marker disagreeing with the length-derived end
    assign o_cpl_err = cpl_hs && (i_cpl_last != last_beat);
`else
    logic unused_cpl_last;
    assign unused_cpl_last = i_cpl_last;
    assign o_cpl_err       = 1'b0;
`endif

endmodule

// File: tb/tb_tl_tx_cpl_write_handler.sv
// Randomized self-checking bench for tl_tx_cpl_write_handler.
// Expected beats/credits/entries come from a DW-remaining model.
module tb_tl_tx_cpl_write_handler;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          cpl_valid;
    logic          cpl_ready;
    logic          fmt_bit;
    logic [9:0]    cpl_length;
    logic [95:0]   cpl_hdr;
    logic [1023:0] cpl_data;
    logic          cpl_last;
    logic [7:0]    hdr_avail;
    logic [11:0]   data_avail;
    logic          hdr_consume;
    logic          data_consume;
    logic [11:0]   consume_value;
    logic          hdr_full;
    logic [7:0]    free_entries;
    logic          hdr_wr_en;
    logic [95:0]   hdr_wr_data;
    logic          data_wr_en;
    logic [2:0]    wr_inc;
    logic [1023:0] wr_data;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_tx_cpl_write_handler dut (
        .i_clk                   (clk),
        .i_n_rst                 (n_rst),
        .i_cpl_valid             (cpl_valid),
        .o_cpl_ready             (cpl_ready),
        .i_cpl_fmt_data_bit      (fmt_bit),
        .i_cpl_length            (cpl_length),
        .i_cpl_hdr               (cpl_hdr),
        .i_cpl_data              (cpl_data),
        .i_cpl_last              (cpl_last),
        .i_fc_hdr_credits_avail  (hdr_avail),
        .i_fc_data_credits_avail (data_avail),
        .o_fc_hdr_consume        (hdr_consume),
        .o_fc_data_consume       (data_consume),
        .o_fc_data_consume_value (consume_value),
        .i_buf_hdr_full          (hdr_full),
        .i_buf_data_free_entries (free_entries),
        .o_buf_hdr_wr_en         (hdr_wr_en),
        .o_buf_hdr_wr_data       (hdr_wr_data),
        .o_buf_data_wr_en        (data_wr_en),
        .o_buf_data_wr_inc       (wr_inc),
        .o_buf_data_wr_data      (wr_data),
        .o_cpl_done              (done),
        .o_cpl_err               (err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] rand_beat();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_ample();
        hdr_avail    = 8'd20;
        data_avail   = 12'd300;
        hdr_full     = 1'b0;
        free_entries = 8'd200;
    endtask

    // One completion TLP; starve>0 withholds one resource for that many cycles
    task automatic send_tlp(input logic fmt, input int len, input bit gaps,
                            input bit bad_last, input int starve,
                            input int mode);
        int dw, rem, nbeats, credits, entries;
        int done_beats, cyc, gap_left, chunk;
        logic [95:0]   hdr;
        logic [1023:0] beat;
        bit last_now, vld;
        dw      = (len == 0) ? 1024 : len;
        nbeats  = fmt ? (dw + 31) / 32 : 1;
        credits = fmt ? (dw + 3) / 4 : 0;
        entries = fmt ? (dw + 7) / 8 : 0;
        rem     = dw;
        hdr     = {$urandom, $urandom, $urandom};
        set_ample();
        if (!fmt && mode < 2) mode = mode + 2;
        if (starve > 0) begin
            case (mode)
                0:       data_avail   = 12'(credits - 1);
                1:       free_entries = 8'(entries - 1);
                2:       hdr_full     = 1'b1;
                default: hdr_avail    = 8'd0;
            endcase
        end
        fmt_bit    = fmt;
        cpl_length = 10'(len);
        cpl_hdr    = hdr;
        done_beats = 0;
        cyc        = 0;
        gap_left   = 0;
        while (done_beats < nbeats && cyc < 400) begin
            if (starve > 0 && cyc == starve) set_ample();
            vld = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            last_now  = (done_beats == nbeats - 1);
            beat      = rand_beat();
            cpl_valid = vld;
            cpl_data  = beat;
            cpl_last  = last_now ^ (bad_last && done_beats == 0);
            @(negedge clk);
            if (cpl_ready && vld) begin
                chunk = fmt ? ((rem > 32) ? 32 : rem) : 0;
                chk("hdr_wr_en", hdr_wr_en, done_beats == 0);
                chk("hdr_consume", hdr_consume, done_beats == 0);
                chk("data_consume", data_consume, done_beats == 0 && fmt);
                chk("consume_value", consume_value,
                    (done_beats == 0) ? credits : 0);
                if (done_beats == 0)
                    chk("hdr_wr_data", hdr_wr_data == hdr, 1);
                chk("data_wr_en", data_wr_en, fmt);
                chk("wr_inc", wr_inc, (chunk + 7) / 8);
                chk("wr_data", wr_data == beat, 1);
                chk("done", done, last_now);
`ifdef TL_TX_CPL_LAST_CHECK_EN
                chk("err", err, cpl_last != last_now);
`else
                chk("err", err, 0);
`endif
                rem = rem - chunk;
                done_beats++;
                if (gaps && done_beats == 1) gap_left = 3;
            end else begin
                chk("idle_strobes", {hdr_wr_en, data_wr_en, wr_inc,
                    hdr_consume, data_consume, done, err}, 0);
                if (starve > 0 && cyc < starve)
                    chk("starve_ready", cpl_ready, 0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("beats", done_beats, nbeats);
        cpl_valid = 1'b0;
        cpl_last  = 1'b0;
        @(negedge clk);
        chk("gap_ready", cpl_ready, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        logic rfmt;
        int rlen, rsel;
        cpl_valid  = 1'b0;
        fmt_bit    = 1'b0;
        cpl_length = '0;
        cpl_hdr    = '0;
        cpl_data   = '0;
        cpl_last   = 1'b0;
        set_ample();
        #2;
        chk("rst_ready", cpl_ready, 0);
        chk("rst_strobes", {hdr_wr_en, data_wr_en, wr_inc,
            hdr_consume, data_consume, done, err}, 0);
        chk("rst_hdr_data", hdr_wr_data == '0, 1);
        chk("rst_wr_data", wr_data == '0, 1);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        send_tlp(1'b1, 1, 0, 0, 0, 0);
        send_tlp(1'b1, 0, 0, 0, 0, 0);
        send_tlp(1'b1, 40, 0, 0, 6, 0);
        send_tlp(1'b0, 17, 0, 0, 0, 0);
        send_tlp(1'b1, 64, 1, 0, 0, 0);

        // Reset in the middle of a 3-beat TLP
        set_ample();
        fmt_bit    = 1'b1;
        cpl_length = 10'd96;
        cpl_hdr    = {$urandom, $urandom, $urandom};
        cpl_data   = rand_beat();
        cpl_valid  = 1'b1;
        cyc = 0;
        while (!cpl_ready && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("pre_rst_ready", cpl_ready, 1);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_ready", cpl_ready, 0);
        chk("mid_rst_strobes", {hdr_wr_en, data_wr_en, wr_inc,
            hdr_consume, data_consume, done, err}, 0);
        chk("mid_rst_hdr", hdr_wr_data == '0, 1);
        cpl_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        send_tlp(1'b1, 8, 0, 0, 0, 0);
        send_tlp(1'b1, 64, 0, 1, 0, 0);

        for (int i = 0; i < 25; i++) begin
            rfmt = ($urandom_range(0, 3) != 0);
            rsel = $urandom_range(0, 3);
            case (rsel)
                0:       rlen = 0;
                1:       rlen = $urandom_range(1, 40);
                default: rlen = $urandom_range(0, 1023);
            endcase
            send_tlp(rfmt, rlen, bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(3, 6) : 0,
                     $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
